ext_mem_router: RTL



---
 rtl/ext_mem_pkg.sv | 27 ++
 rtl/ext_mem_decoder.sv | 46 ++++
 rtl/ext_mem_router.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ext_mem_pkg.sv
// ext_mem_pkg
// Shared types and default constants for the external-memory router and
// its address decoder.
//   state_t          : router FSM states (IDLE / ACCESS / RESP)
//   DEF_*            : default address width, region count, base and mask tables
//                      (index 0 = flash, 1 = SRAM, 2 = LEDs, 3 = SDRAM)
//   region_idx_t     : region index sized for the default region count
package ext_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int DEF_ADDR_W      = 24;
    localparam int DEF_NUM_REGIONS = 4;

    // Packed tables: the right-most entry is region 0.
    localparam logic [DEF_NUM_REGIONS-1:0][DEF_ADDR_W-1:0] DEF_REGION_BASE =
        {24'h800000, 24'h480000, 24'h400000, 24'h000000};
    localparam logic [DEF_NUM_REGIONS-1:0][DEF_ADDR_W-1:0] DEF_REGION_MASK =
        {24'h7FFFFF, 24'h000001, 24'h07FFFF, 24'h3FFFFF};

    typedef logic [$clog2(DEF_NUM_REGIONS)-1:0] region_idx_t;

endpackage

// File: rtl/ext_mem_decoder.sv
// ext_mem_decoder
// Combinational address decoder shared by the data- and instruction-port
// routers. A region matches when (addr & ~mask) == base; when several
// regions match, the lowest index wins.
// Ports:
//   addr   in  ADDR_W  CPU word address
//   hit    out 1       some region matches
//   idx    out IDX_W   winning region index (0 when no hit)
//   offset out ADDR_W  addr & mask of the winning region (0 when no hit)
module ext_mem_decoder
    import ext_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] offset
);

    logic [NUM_REGIONS-1:0] match_s;

    // Per-region match vector.
    always_comb begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            match_s[i] = ((addr & ~REGION_MASK[i]) == REGION_BASE[i]);
        end
    end

    // Priority select: walking from the top index down lets lower indices
    // overwrite higher ones, so the lowest matching region is the result.
    always_comb begin
        hit    = |match_s;
        idx    = '0;
        offset = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            idx    = match_s[i] ? IDX_W'(i) : idx;
            offset = match_s[i] ? (addr & REGION_MASK[i]) : offset;
        end
    end

endmodule

// File: rtl/ext_mem_router.sv
// ext_mem_router
// Routes one CPU request at a time to one of NUM_REGIONS downstream
// channels through a registered IDLE -> ACCESS -> RESP state machine.
// Unmapped addresses and simultaneous read+write complete in one cycle
// with cpu_err_o set. Optional access timeout: define EXT_MEM_TIMEOUT_EN.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cpu_addr_i/wdata_i/be_i     request address, write data, byte enables
//   cpu_re_i/we_i               read / write request (held while cpu_wait_o)
//   cpu_rdata_o/err_o           result, valid while in RESP
//   cpu_wait_o                  CPU holds the request while high
//   mem_addr_o                  per-channel offset (selected channel only)
//   mem_wdata_o/be_o            shared write data / byte enables
//   mem_re_o/we_o               per-channel strobes
//   mem_rdata_i/wait_i          per-channel read data / wait
module ext_mem_router
    import ext_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = 16,
    parameter int NUM_REGIONS = DEF_NUM_REGIONS,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             cpu_addr_i,
    input  logic [DATA_W-1:0]             cpu_wdata_i,
    input  logic [DATA_W/8-1:0]           cpu_be_i,
    input  logic                          cpu_re_i,
    input  logic                          cpu_we_i,
    output logic [DATA_W-1:0]             cpu_rdata_o,
    output logic                          cpu_wait_o,
    output logic                          cpu_err_o,
    output logic [NUM_REGIONS*ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    output logic [DATA_W/8-1:0]           mem_be_o,
    output logic [NUM_REGIONS-1:0]        mem_re_o,
    output logic [NUM_REGIONS-1:0]        mem_we_o,
    input  logic [NUM_REGIONS*DATA_W-1:0] mem_rdata_i,
    input  logic [NUM_REGIONS-1:0]        mem_wait_i
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int BE_W  = DATA_W / 8;

    state_t                        state_r, state_nxt_s;
    logic [IDX_W-1:0]              sel_r, sel_nxt_s;
    logic                          we_dir_r, we_dir_nxt_s;
    logic [NUM_REGIONS*ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [DATA_W-1:0]             wdata_r, wdata_nxt_s;
    logic [BE_W-1:0]               be_r, be_nxt_s;
    logic [NUM_REGIONS-1:0]        re_r, re_nxt_s, we_r, we_nxt_s;
    logic [DATA_W-1:0]             rdata_r, rdata_nxt_s;
    logic                          err_r, err_nxt_s;

    logic                          hit_s;
    logic [IDX_W-1:0]              idx_s;
    logic [ADDR_W-1:0]             offset_s;
    logic                          req_s;
    logic                          illegal_s;
    logic                          sel_wait_s;
    logic [DATA_W-1:0]             sel_rdata_s;
    logic                          timeout_s;

    ext_mem_decoder #(
        .ADDR_W      (ADDR_W),
        .NUM_REGIONS (NUM_REGIONS),
        .IDX_W       (IDX_W),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_decoder (
        .addr   (cpu_addr_i),
        .hit    (hit_s),
        .idx    (idx_s),
        .offset (offset_s)
    );

    assign req_s       = cpu_re_i | cpu_we_i;
    assign illegal_s   = cpu_re_i & cpu_we_i;
    assign sel_wait_s  = mem_wait_i[sel_r];
    assign sel_rdata_s = mem_rdata_i[int'(sel_r)*DATA_W +: DATA_W];

`ifdef EXT_MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;

    // The counter holds the number of ACCESS cycles already completed, so the
    // final allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter next value: counts ACCESS cycles, zero everywhere else so it is
    // already cleared on entry to ACCESS.
    always_comb begin
        if (state_r == ACCESS) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-register logic for the request/completion FSM.
    always_comb begin
        state_nxt_s  = state_r;
        sel_nxt_s    = sel_r;
        we_dir_nxt_s = we_dir_r;
        addr_nxt_s   = addr_r;
        wdata_nxt_s  = wdata_r;
        be_nxt_s     = be_r;
        re_nxt_s     = re_r;
        we_nxt_s     = we_r;
        rdata_nxt_s  = rdata_r;
        err_nxt_s    = err_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    sel_nxt_s    = idx_s;
                    we_dir_nxt_s = cpu_we_i;
                    wdata_nxt_s  = cpu_wdata_i;
                    be_nxt_s     = cpu_be_i;
                    // Only the selected channel sees an offset; the rest read 0.
                    addr_nxt_s   = '0;
                    addr_nxt_s[int'(idx_s)*ADDR_W +: ADDR_W] = offset_s;
                    re_nxt_s     = '0;
                    we_nxt_s     = '0;
                    if (hit_s && !illegal_s) begin
                        state_nxt_s     = ACCESS;
                        re_nxt_s[idx_s] = cpu_re_i;
                        we_nxt_s[idx_s] = cpu_we_i;
                    end else begin
                        state_nxt_s = RESP;
                        rdata_nxt_s = '0;
                        err_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                // Completion is tested first so it wins over a same-cycle timeout.
                if (!sel_wait_s) begin
                    state_nxt_s = RESP;
                    re_nxt_s    = '0;
                    we_nxt_s    = '0;
                    rdata_nxt_s = we_dir_r ? '0 : sel_rdata_s;
                    err_nxt_s   = 1'b0;
                end else if (timeout_s) begin
                    state_nxt_s = RESP;
                    re_nxt_s    = '0;
                    we_nxt_s    = '0;
                    rdata_nxt_s = '0;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                re_nxt_s    = '0;
                we_nxt_s    = '0;
            end
        endcase
    end

    // FSM state and datapath registers; every mem_* output is driven from here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            sel_r    <= '0;
            we_dir_r <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            be_r     <= '0;
            re_r     <= '0;
            we_r     <= '0;
            rdata_r  <= '0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            sel_r    <= sel_nxt_s;
            we_dir_r <= we_dir_nxt_s;
            addr_r   <= addr_nxt_s;
            wdata_r  <= wdata_nxt_s;
            be_r     <= be_nxt_s;
            re_r     <= re_nxt_s;
            we_r     <= we_nxt_s;
            rdata_r  <= rdata_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

    // In IDLE the wait flag follows the request directly so a new request is
    // stalled from its first cycle; it is forced low while reset is asserted.
    assign cpu_wait_o  = ~reset & ((state_r == IDLE) ? req_s : (state_r == ACCESS));
    assign cpu_rdata_o = rdata_r;
    assign cpu_err_o   = err_r;
    assign mem_addr_o  = addr_r;
    assign mem_wdata_o = wdata_r;
    assign mem_be_o    = be_r;
    assign mem_re_o    = re_r;
    assign mem_we_o    = we_r;

endmodule
